// File: rtl/kare_pkg.sv
// Shared definitions for the squaring stage and the sum-of-squares accumulator.
package kare_pkg;
    localparam int SQ_W      = 8;
    localparam int CNT_W_DEF = 4;
    localparam int ACC_W_DEF = SQ_W + CNT_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } kare_state_t;
endpackage

// File: rtl/kare_toplayici_4bit.sv
// Sum-of-squares accumulator: collects a burst of 8-bit squares, holds the total until taken.
// Optional max_out port (largest accepted square) is built when KARE_TOPLAYICI_MAX_EN is defined.
module kare_toplayici_4bit
    import kare_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = SQ_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [SQ_W-1:0]   kare_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
`ifdef KARE_TOPLAYICI_MAX_EN
    ,
    output logic [SQ_W-1:0]   max_out
`endif
);

    kare_state_t       r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_rem;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
`ifdef KARE_TOPLAYICI_MAX_EN
    logic [SQ_W-1:0]   r_max;
`endif

    logic [ACC_W-1:0]  w_kare_ext;
    logic              w_accept;
    logic              w_len_nz;

    assign w_kare_ext = {{(ACC_W-SQ_W){1'b0}}, kare_in};
    assign w_accept   = in_valid & r_in_ready;
    assign w_len_nz   = (len != {CNT_W{1'b0}});

    // Burst control FSM with registered handshake outputs, accumulator and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= {ACC_W{1'b0}};
            r_rem       <= {CNT_W{1'b0}};
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef KARE_TOPLAYICI_MAX_EN
            r_max       <= {SQ_W{1'b0}};
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    // A zero-length request would never produce a beat, so it is dropped here.
                    if (start && w_len_nz) begin
                        r_state    <= ACC;
                        r_acc      <= {ACC_W{1'b0}};
                        r_rem      <= len;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
`ifdef KARE_TOPLAYICI_MAX_EN
                        r_max      <= {SQ_W{1'b0}};
`endif
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_kare_ext;
                        r_rem <= r_rem - {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef KARE_TOPLAYICI_MAX_EN
                        if (kare_in > r_max) begin
                            r_max <= kare_in;
                        end
`endif
                        if (r_rem == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum_out   = r_acc;
`ifdef KARE_TOPLAYICI_MAX_EN
    assign max_out   = r_max;
`endif

endmodule

// File: tb/tb_kare_toplayici_4bit.sv
// Self-checking bench for kare_toplayici_4bit: directed bursts from the test plan plus random bursts
// checked against sums computed directly from the list of squares sent.
module tb_kare_toplayici_4bit;
    import kare_pkg::*;

    localparam int CNT_W = CNT_W_DEF;
    localparam int ACC_W = ACC_W_DEF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic [7:0]        kare_in;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  sum_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
`ifdef KARE_TOPLAYICI_MAX_EN
    logic [7:0]        max_out;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] q[$];

    kare_toplayici_4bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .kare_in   (kare_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_out   (sum_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef KARE_TOPLAYICI_MAX_EN
        ,
        .max_out   (max_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst of the squares in q; gaps/stall cycles insert idle input and output backpressure.
    task automatic run_burst(input int gap_max, input int stall, input bit start_on_take);
        int exp_sum;
        int exp_max;
        int n;
        exp_sum = 0;
        exp_max = 0;
        n = q.size();
        foreach (q[i]) begin
            exp_sum += int'(q[i]);
            if (int'(q[i]) > exp_max) exp_max = int'(q[i]);
        end
        start = 1'b1;
        len   = CNT_W'(n);
        step();
        start = 1'b0;
        chk("start_in_ready", 32'(in_ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(gap_max, 0);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                kare_in  = 8'($urandom);
                step();
            end
            chk("beat_in_ready", 32'(in_ready), 32'd1);
            chk("beat_no_out_valid", 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            kare_in  = q[i];
            step();
            in_valid = 1'b0;
        end
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_sum", 32'(sum_out), 32'(exp_sum));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
`ifdef KARE_TOPLAYICI_MAX_EN
        chk("done_max", 32'(max_out), 32'(exp_max));
`endif
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            start     = 1'b1;
            len       = 4'd3;
            in_valid  = 1'b1;
            kare_in   = 8'd77;
            step();
            start    = 1'b0;
            in_valid = 1'b0;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(sum_out), 32'(exp_sum));
        end
        out_ready = 1'b1;
        if (start_on_take) begin
            start = 1'b1;
            len   = 4'd5;
        end
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("take_out_valid", 32'(out_valid), 32'd0);
        chk("take_busy", 32'(busy), 32'd0);
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        kare_in   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Basic burst
        q = '{8'd9, 8'd49, 8'd225};
        run_burst(0, 0, 1'b0);

        // Gapped input with backpressure and starts during DONE
        q = '{8'd4, 8'd16};
        start = 1'b1; len = 4'd2; step(); start = 1'b0;
        chk("gap_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; kare_in = 8'd4; step(); in_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            kare_in = 8'd200;
            step();
            chk("gap_idle_sum", 32'(sum_out), 32'd4);
        end
        in_valid = 1'b1; kare_in = 8'd16; step(); in_valid = 1'b0;
        chk("gap_out_valid", 32'(out_valid), 32'd1);
        chk("gap_sum", 32'(sum_out), 32'd20);
        q = '{};
        for (int s = 0; s < 5; s++) begin
            start = 1'b1; len = 4'd7; step(); start = 1'b0;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(sum_out), 32'd20);
        end
        out_ready = 1'b1; start = 1'b1; len = 4'd2; step();
        out_ready = 1'b0; start = 1'b0;
        chk("bp_take_busy", 32'(busy), 32'd0);
        step();
        chk("bp_idle_in_ready", 32'(in_ready), 32'd0);

        // Full-scale burst
        q = {};
        for (int i = 0; i < 15; i++) q.push_back(8'd225);
        run_burst(0, 1, 1'b1);

        // len = 0 is ignored
        start = 1'b1; len = 4'd0; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("len0_in_ready", 32'(in_ready), 32'd0);
            chk("len0_busy", 32'(busy), 32'd0);
            chk("len0_out_valid", 32'(out_valid), 32'd0);
            step();
        end

        // Reset in the middle of a burst
        start = 1'b1; len = 4'd4; step(); start = 1'b0;
        in_valid = 1'b1; kare_in = 8'd100; step();
        kare_in = 8'd121; step(); in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #2;
        chk("midrst_sum", 32'(sum_out), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
`ifdef KARE_TOPLAYICI_MAX_EN
        chk("midrst_max", 32'(max_out), 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        q = '{8'd1};
        run_burst(0, 0, 1'b0);

        // Max-tracking bursts (max also checked inside run_burst when enabled)
        q = '{8'd36, 8'd144, 8'd81};
        run_burst(1, 2, 1'b0);
        q = '{8'd1};
        run_burst(0, 0, 1'b0);

        // Randomized bursts
        for (int b = 0; b < 20; b++) begin
            int n;
            n = $urandom_range(15, 1);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255, 0)));
            run_burst(2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/kare_toplayici_4bit.md
# kare_toplayici_4bit

Sequential sum-of-squares accumulator sitting directly downstream of the 4-bit squaring stage of the ALU. It accepts a burst of 8-bit square values over a valid/ready handshake and accumulates them into a widened sum. When the programmed burst length is reached, it presents the result on a held output handshake. The block gives the ALU a multi-cycle "sum of squares" operation without changing the combinational squarer.

## Interface
- CNT_W, 4, width of burst-length field; max burst = 2^CNT_W − 1
- ACC_W, 8+CNT_W, accumulator/result width; sized so the sum can never overflow
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE
- len  in  CNT_W  number of squares in the burst; sampled with start
- kare_in  in  8  square value from the squaring stage
- in_valid  in  1  kare_in valid
- in_ready  out  1  block accepts kare_in this cycle
- sum_out  out  ACC_W  accumulated sum of squares
- out_valid  out  1  sum_out valid, held until taken
- out_ready  in  1  consumer accepts sum_out
- busy  out  1  high in ACC or DONE

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE: in_ready=0, out_valid=0.
  - start=1 with len≠0: clear accumulator, load remaining count with len, go to ACC.
  - start=1 with len=0: ignored; stay in IDLE, no output.
- ACC: in_ready=1.
  - Each cycle with in_valid&in_ready: acc += zero-extended kare_in; remaining −= 1.
  - When the accepted beat has remaining==1: go to DONE.
  - Cycles with in_valid=0 change nothing.
- DONE: in_ready=0, out_valid=1, sum_out = acc, held stable.
  - out_valid&out_ready: go to IDLE.
- start outside IDLE is ignored, including a start in the same cycle as the DONE→IDLE handshake.
- Arithmetic: unsigned. Max sum 225·(2^CNT_W−1) < 2^ACC_W, so no saturation or wrap logic.
- kare_in is not checked for being a perfect square; any 8-bit value is summed.

## Timing
- Reset values:
  - state=IDLE, acc=0, remaining=0.
  - sum_out=0, out_valid=0, in_ready=0, busy=0.
- Reset is asynchronous; assertion mid-burst or mid-DONE discards everything. The result is never emitted.
- Start → ACC: the cycle after start is sampled, in_ready=1.
- Last accepted beat at edge k → out_valid=1 and sum_out final from edge k (visible in cycle k+1).
- Minimum burst occupancy: len+2 cycles from start to out_valid if in_valid is held high.
- out_valid may stall indefinitely. sum_out must not change while out_valid=1 and out_ready=0.
- in_ready is a registered function of state only, with no combinational path from in_valid.

## Configuration
- KARE_TOPLAYICI_MAX_EN defined:
  - Adds output max_out[7:0], the largest kare_in accepted in the current burst.
  - max_out is cleared at start, updated with acc, and valid/held under the same out_valid rule.
  - Reset value is 0.
- Not defined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package kare_pkg holds:
  - the state enum (IDLE, ACC, DONE)
  - the default CNT_W and the derived ACC_W localparam
  - the 8-bit square width constant used by the squarer and this block
- Single flat module, with no sub-module. The counter and accumulator are small enough to stay inline.

## Test plan
- Basic burst: start, len=3, squares 9, 49, 225 back-to-back → out_valid one cycle after the third beat, sum_out=283. Take with out_ready=1 → IDLE.
- Gapped input with backpressure:
  - len=2, squares 4 and 16 with 3 idle cycles between → sum_out=20.
  - Hold out_ready=0 for 5 cycles → sum_out and out_valid stable; start pulses during DONE ignored.
- Full-scale: len=15, all squares 225 → sum_out=3375, no wrap (ACC_W=12).
- len=0: start pulse → block stays IDLE, in_ready=0, busy=0, no out_valid.
- Reset mid-burst:
  - len=4, accept 2 beats, pulse rst_n low → all outputs at reset values.
  - New burst len=1, square 1 → sum_out=1 (no residue).
- Macro on: len=3, squares 36, 144, 81 → sum_out=261, max_out=144. Next burst len=1, square 1 → max_out=1.
